// File: rtl/apb4_archinfo_ext_pkg.sv
// Shared definitions for the APB4 architecture-info slave: word offsets,
// CTRL bit positions, register-select encoding and the STAT word builder.
package apb4_archinfo_ext_pkg;

  localparam int NUM_ID_MAX = 8;
  localparam int IDX_W      = $clog2(NUM_ID_MAX);

  // Word offsets (byte address >> 2)
  localparam int CTRL_WORD    = 0;
  localparam int STAT_WORD    = 1;
  localparam int CNTL_WORD    = 2;
  localparam int CNTH_WORD    = 3;
  localparam int SCR_WORD     = 4;
  localparam int ID_BASE_WORD = 8;

  // CTRL bit indices
  localparam int CTRL_LOCK = 0;
  localparam int CTRL_EN   = 1;
  localparam int CTRL_CLR  = 2;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STAT,
    REG_CNTL,
    REG_CNTH,
    REG_SCR,
    REG_ID,
    REG_NONE
  } reg_sel_e;

  // STAT layout: [31:16] PRESC, [7:4] NUM_ID, [0] locked
  function automatic logic [31:0] stat_word(input logic locked, input int num_id,
                                            input int presc);
    logic [31:0] w;
    w        = '0;
    w[31:16] = 16'(presc);
    w[7:4]   = 4'(num_id);
    w[0]     = locked;
    return w;
  endfunction

endpackage

// File: rtl/apb4_archinfo_ext_if.sv
// APB4 peripheral bus bundle (no pstrb/pprot) with master and slave views.
interface apb4_archinfo_ext_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_archinfo_ext_uptime.sv
// Prescaled 64-bit uptime counter with a high-word shadow captured on
// low-word reads, so software sees a consistent low/high pair.
module apb4_archinfo_ext_uptime #(
  parameter int PRESC = 1
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        snap_i,
  output logic [31:0] cnt_lo_o,
  output logic [31:0] shadow_o
);

  logic [15:0] pre_q, pre_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  // Next state: clear beats increment; snapshot takes the pre-increment high word
  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (clr_i) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      if (pre_q == 16'(PRESC - 1)) begin
        pre_d = '0;
        cnt_d = cnt_q + 64'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
    if (snap_i) begin
      shadow_d = cnt_q[63:32];
    end
  end

  // Counter state registers
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign cnt_lo_o = cnt_q[31:0];
  assign shadow_o = shadow_q;

endmodule

// File: rtl/apb4_archinfo_ext.sv
// APB4 architecture-info slave: ID words with sticky write-lock, control,
// status, scratch and a prescaled uptime counter. Zero wait states.
module apb4_archinfo_ext
  import apb4_archinfo_ext_pkg::*;
#(
  parameter int                   NUM_ID = 4,
  parameter logic [NUM_ID*32-1:0] ID_RST = {NUM_ID{32'hFFFF_FFFF}},
  parameter int                   PRESC  = 1,
  parameter int                   ADDR_W = 8
) (
  input  logic                 hclk,
  input  logic                 hrst,
  apb4_archinfo_ext_if.slave   bus,
  output logic [NUM_ID*32-1:0] id_o,
  output logic                 locked_o
);

  reg_sel_e             sel;
  logic [IDX_W-1:0]     id_idx;
  int                   widx;
  logic                 access, err, wr_ok, snap, clr;
  logic [31:0]          rdata, cnt_lo, shadow;
  logic                 lock_q, lock_d;
  logic                 en_q, en_d;
  logic [31:0]          scr_q, scr_d;
  logic [NUM_ID*32-1:0] id_q, id_d;
  logic                 unused_paddr;

  assign unused_paddr = ^bus.paddr[1:0];
  assign access       = bus.psel & bus.penable;

  // Address decode to a register select (byte lane bits ignored)
  always_comb begin
    widx   = int'(bus.paddr[ADDR_W-1:2]);
    sel    = REG_NONE;
    id_idx = '0;
    if (widx == CTRL_WORD)      sel = REG_CTRL;
    else if (widx == STAT_WORD) sel = REG_STAT;
    else if (widx == CNTL_WORD) sel = REG_CNTL;
    else if (widx == CNTH_WORD) sel = REG_CNTH;
    else if (widx == SCR_WORD)  sel = REG_SCR;
    else if (widx >= ID_BASE_WORD && widx < ID_BASE_WORD + NUM_ID) begin
      sel    = REG_ID;
      id_idx = IDX_W'(widx - ID_BASE_WORD);
    end
  end

  // Error response: writes to read-only words, locked ID writes, unmapped words
  always_comb begin
    err = 1'b0;
    if (access) begin
      case (sel)
        REG_STAT, REG_CNTL, REG_CNTH: err = bus.pwrite;
        REG_ID:                       err = bus.pwrite & lock_q;
        REG_NONE:                     err = 1'b1;
        default:                      err = 1'b0;
      endcase
    end
  end

  assign wr_ok = access & bus.pwrite & ~err;
  assign snap  = access & ~bus.pwrite & (sel == REG_CNTL);
  assign clr   = wr_ok & (sel == REG_CTRL) & bus.pwdata[CTRL_CLR];

  // Register next state; an erroring access leaves everything untouched
  always_comb begin
    lock_d = lock_q;
    en_d   = en_q;
    scr_d  = scr_q;
    id_d   = id_q;
    if (wr_ok) begin
      if (sel == REG_CTRL) begin
        lock_d = lock_q | bus.pwdata[CTRL_LOCK];
        en_d   = bus.pwdata[CTRL_EN];
      end
      if (sel == REG_SCR) begin
        scr_d = bus.pwdata;
      end
      for (int i = 0; i < NUM_ID; i++) begin
        if (sel == REG_ID && id_idx == IDX_W'(i)) begin
          id_d[32*i +: 32] = bus.pwdata;
        end
      end
    end
  end

  // Control, scratch and ID registers
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      lock_q <= 1'b0;
      en_q   <= 1'b1;
      scr_q  <= '0;
      id_q   <= ID_RST;
    end else begin
      lock_q <= lock_d;
      en_q   <= en_d;
      scr_q  <= scr_d;
      id_q   <= id_d;
    end
  end

  apb4_archinfo_ext_uptime #(
    .PRESC (PRESC)
  ) u_up (
    .hclk     (hclk),
    .hrst     (hrst),
    .en_i     (en_q),
    .clr_i    (clr),
    .snap_i   (snap),
    .cnt_lo_o (cnt_lo),
    .shadow_o (shadow)
  );

  // Combinational read mux; errors return zero
  always_comb begin
    rdata = '0;
    if (!err) begin
      case (sel)
        REG_CTRL: rdata = {29'd0, 1'b0, en_q, lock_q};
        REG_STAT: rdata = stat_word(lock_q, NUM_ID, PRESC);
        REG_CNTL: rdata = cnt_lo;
        REG_CNTH: rdata = shadow;
        REG_SCR:  rdata = scr_q;
        REG_ID: begin
          for (int i = 0; i < NUM_ID; i++) begin
            if (id_idx == IDX_W'(i)) rdata = id_q[32*i +: 32];
          end
        end
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.prdata  = rdata;
  assign bus.pready  = 1'b1;
  assign bus.pslverr = err;
  assign id_o        = id_q;
  assign locked_o    = lock_q;

endmodule

// File: tb/tb_apb4_archinfo_ext.sv
// Directed plus randomized bench for apb4_archinfo_ext (NUM_ID=4, PRESC=4).
module tb_apb4_archinfo_ext;

  localparam int NUM_ID = 4;
  localparam int PRESC  = 4;
  localparam int ADDR_W = 8;
  localparam logic [NUM_ID*32-1:0] ID_RST = {NUM_ID{32'hFFFF_FFFF}};

  logic                 hclk = 1'b0;
  logic                 hrst;
  logic [NUM_ID*32-1:0] id_o;
  logic                 locked_o;

  apb4_archinfo_ext_if #(.ADDR_W(ADDR_W)) bus ();

  apb4_archinfo_ext #(
    .NUM_ID (NUM_ID),
    .ID_RST (ID_RST),
    .PRESC  (PRESC),
    .ADDR_W (ADDR_W)
  ) dut (
    .hclk     (hclk),
    .hrst     (hrst),
    .bus      (bus),
    .id_o     (id_o),
    .locked_o (locked_o)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;
  logic setup_err;

  // Reference model state
  logic [31:0] id_m [NUM_ID];
  logic [31:0] scr_m, shadow_m;
  logic        lock_m;

  logic [31:0] rd, d, exp_rd, a, b;
  logic        er, wr, exp_er, mapped;
  int          w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr_i, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd_o, output logic er_o);
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr_i;
    bus.paddr = addr; bus.pwdata = wd;
    #1 setup_err = bus.pslverr;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    #1;
    rd_o = bus.prdata;
    er_o = bus.pslverr;
    @(posedge hclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  function automatic logic [31:0] stat_m(input logic lk);
    return {16'(PRESC), 8'h00, 4'(NUM_ID), 3'b000, lk};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    hrst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    repeat (3) @(posedge hclk);
    #1 hrst = 1'b0;
    #1;

    // Reset state
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_pready", 32'(bus.pready), 32'd1);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    for (int i = 0; i < NUM_ID; i++) check("rst_id_o", id_o[32*i +: 32], 32'hFFFF_FFFF);

    for (int i = 0; i < NUM_ID; i++) begin
      apb(1'b0, 8'(8'h20 + 4 * i), 32'd0, rd, er);
      check("id_rst_read", rd, 32'hFFFF_FFFF);
      check("id_rst_err", 32'(er), 32'd0);
    end
    apb(1'b0, 8'h04, 32'd0, rd, er);
    check("stat_rst", rd, stat_m(1'b0));
    apb(1'b0, 8'h00, 32'd0, rd, er);
    check("ctrl_rst", rd, 32'h0000_0002);

    // ID write, then lock
    apb(1'b1, 8'h20, 32'h1234_5678, rd, er);
    check("id0_wr_err", 32'(er), 32'd0);
    apb(1'b0, 8'h20, 32'd0, rd, er);
    check("id0_readback", rd, 32'h1234_5678);
    apb(1'b1, 8'h00, 32'h0000_0003, rd, er);
    check("lock_wr_err", 32'(er), 32'd0);
    check("locked_o_set", 32'(locked_o), 32'd1);
    apb(1'b1, 8'h00, 32'h0000_0002, rd, er);
    check("lock_sticky", 32'(locked_o), 32'd1);
    apb(1'b1, 8'h20, 32'h0000_0000, rd, er);
    check("locked_id_err", 32'(er), 32'd1);
    apb(1'b0, 8'h20, 32'd0, rd, er);
    check("locked_id_kept", rd, 32'h1234_5678);
    apb(1'b0, 8'h04, 32'd0, rd, er);
    check("stat_locked", rd, stat_m(1'b1));
    apb(1'b1, 8'h10, 32'hA5A5_A5A5, rd, er);
    check("scr_locked_err", 32'(er), 32'd0);
    apb(1'b0, 8'h10, 32'd0, rd, er);
    check("scr_readback", rd, 32'hA5A5_A5A5);

    // Reset asserted during the access phase of an ID write
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h24; bus.pwdata = 32'hDEAD_BEEF;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    #1 hrst = 1'b1;
    #1;
    check("async_rst_locked", 32'(locked_o), 32'd0);
    check("async_rst_id0", id_o[31:0], 32'hFFFF_FFFF);
    @(posedge hclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    hrst = 1'b0;
    apb(1'b0, 8'h24, 32'd0, rd, er);
    check("inflight_lost", rd, 32'hFFFF_FFFF);
    apb(1'b0, 8'h10, 32'd0, rd, er);
    check("scr_after_rst", rd, 32'd0);
    apb(1'b0, 8'h00, 32'd0, rd, er);
    check("ctrl_after_rst", rd, 32'h0000_0002);

    // Prescaled counting, freeze, clear
    apb(1'b1, 8'h00, 32'h0000_0006, rd, er);
    repeat (40) @(posedge hclk);
    apb(1'b0, 8'h08, 32'd0, rd, er);
    check("cnt_40_range", 32'(rd >= 32'd9 && rd <= 32'd10), 32'd1);
    apb(1'b0, 8'h0C, 32'd0, rd, er);
    check("cnth_small", rd, 32'd0);
    apb(1'b1, 8'h00, 32'h0000_0000, rd, er);
    apb(1'b0, 8'h08, 32'd0, a, er);
    repeat (20) @(posedge hclk);
    apb(1'b0, 8'h08, 32'd0, b, er);
    check("cnt_frozen", b, a);
    check("cnt_frozen_nonzero", 32'(a >= 32'd10), 32'd1);
    apb(1'b1, 8'h00, 32'h0000_0004, rd, er);
    apb(1'b0, 8'h08, 32'd0, rd, er);
    check("cnt_cleared", rd, 32'd0);

    // Low-word wrap while reading CNTL on the increment edge
    apb(1'b1, 8'h00, 32'h0000_0002, rd, er);
    @(posedge hclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h08;
    @(posedge hclk); #1;
    bus.penable = 1'b1;
    force dut.u_up.cnt_q = 64'h0000_0000_FFFF_FFFF;
    force dut.u_up.pre_q = 16'(PRESC - 1);
    #1;
    release dut.u_up.cnt_q;
    release dut.u_up.pre_q;
    #1;
    check("wrap_low", bus.prdata, 32'hFFFF_FFFF);
    check("wrap_err", 32'(bus.pslverr), 32'd0);
    @(posedge hclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    apb(1'b0, 8'h0C, 32'd0, rd, er);
    check("wrap_cnth_pre", rd, 32'd0);
    apb(1'b0, 8'h08, 32'd0, rd, er);
    check("wrap_low_after", 32'(rd <= 32'd1), 32'd1);
    apb(1'b0, 8'h0C, 32'd0, rd, er);
    check("wrap_cnth_post", rd, 32'd1);

    // Clear and stop the counter; error cases
    apb(1'b1, 8'h00, 32'h0000_0004, rd, er);
    apb(1'b0, 8'h30, 32'd0, rd, er);
    check("unmapped_rd_err", 32'(er), 32'd1);
    check("unmapped_rd_data", rd, 32'd0);
    apb(1'b1, 8'h30, 32'h1111_1111, rd, er);
    check("unmapped_wr_err", 32'(er), 32'd1);
    apb(1'b1, 8'h08, 32'h2222_2222, rd, er);
    check("cntl_wr_err", 32'(er), 32'd1);
    check("cntl_wr_data", rd, 32'd0);
    check("setup_no_err", 32'(setup_err), 32'd0);
    apb(1'b1, 8'h04, 32'h3333_3333, rd, er);
    check("stat_wr_err", 32'(er), 32'd1);
    apb(1'b1, 8'h0C, 32'h4444_4444, rd, er);
    check("cnth_wr_err", 32'(er), 32'd1);
    apb(1'b0, 8'h14, 32'd0, rd, er);
    check("gap_rd_err", 32'(er), 32'd1);
    for (int i = 0; i < NUM_ID; i++) check("no_id_change", id_o[32*i +: 32], 32'hFFFF_FFFF);
    apb(1'b0, 8'h04, 32'd0, rd, er);
    check("stat_unchanged", rd, stat_m(1'b0));

    // Randomized traffic against the reference model
    for (int i = 0; i < NUM_ID; i++) id_m[i] = 32'hFFFF_FFFF;
    scr_m    = 32'd0;
    lock_m   = 1'b0;
    shadow_m = 32'd1;
    for (int n = 0; n < 300; n++) begin
      w  = int'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (w == 0) begin
        d[1] = 1'b0;
        d[0] = ($urandom_range(0, 15) == 0);
      end
      mapped = (w <= 4) || (w >= 8 && w < 8 + NUM_ID);
      exp_er = !mapped || (wr && (w >= 1 && w <= 3)) || (wr && w >= 8 && lock_m);
      exp_rd = 32'd0;
      if (!exp_er) begin
        if (w == 0)      exp_rd = {31'd0, lock_m};
        else if (w == 1) exp_rd = stat_m(lock_m);
        else if (w == 2) exp_rd = 32'd0;
        else if (w == 3) exp_rd = shadow_m;
        else if (w == 4) exp_rd = scr_m;
        else             exp_rd = id_m[w - 8];
      end
      apb(wr, 8'(4 * w), d, rd, er);
      check("rand_err", 32'(er), 32'(exp_er));
      if (!wr) check("rand_rdata", rd, exp_rd);
      if (!exp_er) begin
        if (wr) begin
          if (w == 0)      lock_m = lock_m | d[0];
          else if (w == 4) scr_m = d;
          else if (w >= 8) id_m[w - 8] = d;
        end else if (w == 2) begin
          shadow_m = 32'd0;
        end
      end
    end
    for (int i = 0; i < NUM_ID; i++) check("rand_id_o", id_o[32*i +: 32], id_m[i]);
    check("rand_locked_o", 32'(locked_o), 32'(lock_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
